// File: rtl/systolic_drain_pkg.sv
// Shared parameters and FSM encoding for the systolic-array drain (output collector).
`ifndef DATA_W
`define DATA_W 8
`endif

package systolic_drain_pkg;

  localparam int N          = 3;
  localparam int LAT        = 3;
  localparam int FIFO_DEPTH = 4;
  localparam int CNT_W      = 8;
  localparam int DATA_W     = `DATA_W;
  localparam int EW         = DATA_W + 1;
  localparam int ROW_W      = N * EW;
  // Capture counter must reach num_rows + N - 2 without wrapping.
  localparam int CAP_W      = CNT_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_FLUSH   = 2'd3
  } drain_state_e;

endpackage

// File: rtl/systolic_drain_if.sv
// Bundle of job control, array-side samples and downstream row handshake for the drain.
interface systolic_drain_if;
  import systolic_drain_pkg::*;

  logic             start;
  logic [CNT_W-1:0] num_rows;
  logic [ROW_W-1:0] col_in;
  logic [ROW_W-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             busy;
  logic             done;
  logic             overflow;

  modport master (
    output start, num_rows, col_in, out_ready,
    input  out_data, out_valid, busy, done, overflow
  );

  modport slave (
    input  start, num_rows, col_in, out_ready,
    output out_data, out_valid, busy, done, overflow
  );

endinterface

// File: rtl/systolic_drain_sync_fifo.sv
// First-word-fall-through FIFO with a registered head; push and pop may coincide even when full.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             wr_en, rd_en;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign rd_en = pop && !empty;
  assign wr_en = push && (!full || rd_en);
  assign rdata = rdata_q;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_en) begin
      mem_d[wr_ptr_q[AW-1:0]] = wdata;
      wr_ptr_d                = wr_ptr_q + PTR_ONE;
    end
    if (rd_en) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    // Reading the post-write image gives the bypass when writing into an empty FIFO.
    rdata_d = mem_d[rd_ptr_d[AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      rdata_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      rdata_q  <= rdata_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/systolic_drain.sv
// Collects column-skewed bottom-row sums of the systolic array, re-aligns them into rows
// and hands them downstream through a small FIFO.
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_IDLE    | no job; waiting for start
// ST_WAIT    | array latency before row 0 reaches column 0
// ST_CAPTURE | sampling columns and pushing complete rows
// ST_FLUSH   | all rows captured; waiting for the FIFO to drain, then done
module systolic_drain
  import systolic_drain_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  systolic_drain_if.slave bus
);

  localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(LAT - 2);

  drain_state_e     state_q, state_d;
  logic [CNT_W-1:0] rows_q, rows_d;
  logic [CNT_W-1:0] wait_q, wait_d;
  logic [CAP_W-1:0] cap_q, cap_d;
  logic             overflow_q, overflow_d;

  logic             shift_en, push, pop, done;
  logic             fifo_full, fifo_empty;
  logic             last_cap;
  logic [ROW_W-1:0] row_data, fifo_rdata;

  // Column j is delayed N-1-j cycles so every column of a row lines up with column N-1.
  for (genvar j = 0; j < N; j++) begin : g_col
    if (j < N - 1) begin : g_dly
      localparam int D = N - 1 - j;
      logic [EW-1:0] sr_q [D];
      logic [EW-1:0] sr_d [D];

      always_comb begin
        sr_d = sr_q;
        if (shift_en) begin
          sr_d[0] = bus.col_in[j*EW +: EW];
          for (int k = 1; k < D; k++) begin
            sr_d[k] = sr_q[k-1];
          end
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          for (int k = 0; k < D; k++) begin
            sr_q[k] <= '0;
          end
        end else begin
          sr_q <= sr_d;
        end
      end

      assign row_data[j*EW +: EW] = sr_q[D-1];
    end else begin : g_direct
      assign row_data[j*EW +: EW] = bus.col_in[j*EW +: EW];
    end
  end

  assign last_cap = (cap_q == (CAP_W'(rows_q) + CAP_W'(N - 2)));

  always_comb begin
    state_d  = state_q;
    rows_d   = rows_q;
    wait_d   = wait_q;
    cap_d    = cap_q;
    shift_en = 1'b0;
    push     = 1'b0;
    done     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          rows_d  = bus.num_rows;
          wait_d  = WAIT_LOAD;
          cap_d   = '0;
          state_d = (bus.num_rows == '0) ? ST_FLUSH : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (wait_q == '0) begin
          state_d = ST_CAPTURE;
        end else begin
          wait_d = wait_q - CNT_W'(1);
        end
      end
      ST_CAPTURE: begin
        shift_en = 1'b1;
        push     = (cap_q >= CAP_W'(N - 1));
        if (last_cap) begin
          state_d = ST_FLUSH;
        end else begin
          cap_d = cap_q + CAP_W'(1);
        end
      end
      ST_FLUSH: begin
        if (fifo_empty) begin
          done    = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign pop        = !fifo_empty && bus.out_ready;
  assign overflow_d = overflow_q | (push && fifo_full && !pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      rows_q     <= '0;
      wait_q     <= '0;
      cap_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rows_q     <= rows_d;
      wait_q     <= wait_d;
      cap_q      <= cap_d;
      overflow_q <= overflow_d;
    end
  end

  sync_fifo #(
    .WIDTH (ROW_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (row_data),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign bus.out_data  = fifo_rdata;
  assign bus.out_valid = !fifo_empty;
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.done      = done;
  assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_systolic_drain.sv
// Directed and randomized bench for systolic_drain against a row-queue reference model.
module tb_systolic_drain;
  import systolic_drain_pkg::*;

  localparam int MAXR = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;

  systolic_drain_if dif ();
  systolic_drain dut (.clk(clk), .rst(rst), .bus(dif));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [EW-1:0]    data_t [MAXR][N];
  logic [ROW_W-1:0] mq [$];
  bit  job_active = 1'b0;
  int  job_s      = 0;
  int  job_r      = 0;
  bit  ovf_exp    = 1'b0;
  bit  done_exp   = 1'b0;
  bit  busy_exp   = 1'b0;
  bit  rand_ready = 1'b0;

  task automatic chk(string tag, logic [ROW_W-1:0] obs, logic [ROW_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic chk_bit(string tag, logic obs, logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%0b expected=%0b", tag, cyc, obs, exp);
    end
  endtask

  function automatic logic [ROW_W-1:0] row_of(int r);
    logic [ROW_W-1:0] v;
    for (int j = 0; j < N; j++) v[j*EW +: EW] = data_t[r][j];
    return v;
  endfunction

  // Column j carries row r at cycle start+LAT+r+j; anything else is noise the DUT must ignore.
  task automatic drive_cols();
    logic [ROW_W-1:0] v;
    for (int j = 0; j < N; j++) begin
      int r;
      r = cyc - job_s - LAT - j;
      if (job_active && r >= 0 && r < job_r) v[j*EW +: EW] = data_t[r][j];
      else                                   v[j*EW +: EW] = EW'($urandom);
    end
    dif.col_in = v;
  endtask

  // Mid-cycle: compare DUT against the model, then advance the model across the coming edge.
  task automatic observe();
    int first;
    bit vexp;
    vexp = (mq.size() != 0);
    chk_bit("out_valid", dif.out_valid, vexp);
    if (vexp) chk("out_data", dif.out_data, mq[0]);
    chk_bit("busy", dif.busy, busy_exp);
    chk_bit("done", dif.done, done_exp);
    chk_bit("overflow", dif.overflow, ovf_exp);
    if (rst) begin
      mq.delete();
      job_active = 1'b0;
      ovf_exp    = 1'b0;
      done_exp   = 1'b0;
      busy_exp   = 1'b0;
      return;
    end
    if (done_exp) job_active = 1'b0;
    if (dif.out_ready && mq.size() > 0) void'(mq.pop_front());
    first = job_s + LAT + N - 1;
    if (job_active && job_r > 0 && cyc >= first && cyc < first + job_r) begin
      if (mq.size() < FIFO_DEPTH) mq.push_back(row_of(cyc - first));
      else                        ovf_exp = 1'b1;
    end
    done_exp = job_active && mq.size() == 0 &&
               ((job_r == 0) ? (cyc >= job_s) : (cyc >= first + job_r - 1));
    busy_exp = job_active;
  endtask

  task automatic tick();
    @(negedge clk);
    observe();
    @(posedge clk);
    #1;
    cyc++;
    drive_cols();
    if (rand_ready) dif.out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic start_job(int r, bit pattern);
    for (int rr = 0; rr < r; rr++)
      for (int j = 0; j < N; j++)
        data_t[rr][j] = pattern ? EW'(10 * rr + j) : EW'($urandom);
    job_s        = cyc;
    job_r        = r;
    job_active   = 1'b1;
    dif.start    = 1'b1;
    dif.num_rows = CNT_W'(r);
    tick();
    dif.start    = 1'b0;
    dif.num_rows = CNT_W'($urandom);
  endtask

  task automatic run_until_idle(int limit);
    int n;
    n = 0;
    while (job_active && n < limit) begin
      tick();
      n++;
    end
    chk_bit("job_timeout", job_active, 1'b0);
    chk_bit("all_rows_delivered", mq.size() == 0, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    dif.start     = 1'b0;
    dif.num_rows  = '0;
    dif.out_ready = 1'b0;
    dif.col_in    = '0;
    rst           = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_bit("rst_out_valid", dif.out_valid, 1'b0);
    chk_bit("rst_busy", dif.busy, 1'b0);
    chk_bit("rst_done", dif.done, 1'b0);
    chk_bit("rst_overflow", dif.overflow, 1'b0);
    chk("rst_out_data", dif.out_data, '0);
    rst = 1'b0;
    drive_cols();
    repeat (2) tick();

    // alignment with values 10*r+j, always ready
    dif.out_ready = 1'b1;
    start_job(3, 1'b1);
    run_until_idle(40);

    // backpressure: fill all four slots, then drain
    dif.out_ready = 1'b0;
    start_job(4, 1'b1);
    repeat (LAT + N + 6) tick();
    dif.out_ready = 1'b1;
    run_until_idle(40);

    // overflow: six rows into four slots with no reader
    dif.out_ready = 1'b0;
    start_job(6, 1'b1);
    repeat (14) tick();
    dif.out_ready = 1'b1;
    run_until_idle(40);

    // zero rows
    start_job(0, 1'b0);
    run_until_idle(10);
    repeat (2) tick();

    // second start during capture must be ignored
    start_job(5, 1'b0);
    repeat (4) tick();
    dif.start    = 1'b1;
    dif.num_rows = CNT_W'(9);
    tick();
    dif.start    = 1'b0;
    run_until_idle(40);

    // random data and random downstream readiness
    rand_ready = 1'b1;
    repeat (5) begin
      start_job(int'($urandom_range(1, 8)), 1'b0);
      run_until_idle(200);
      repeat (int'($urandom_range(0, 3))) tick();
    end
    rand_ready    = 1'b0;

    // reset while two rows are queued and capture is still running
    dif.out_ready = 1'b0;
    start_job(5, 1'b0);
    repeat (6) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (2) tick();
    dif.out_ready = 1'b1;
    start_job(1, 1'b0);
    run_until_idle(20);
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
